// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the backpropagation network neurons.
//   Fixed-point widths of the hidden-to-output datapath, the output-neuron
//   FSM state encoding and the supported range of hidden inputs.
package nn_pkg;

  // Hidden output is Q4.4, weights and biases are Q6.10.
  localparam int HID_W      = 8;
  localparam int W_W        = 16;
  // Full product Q10.14; shifting by PROD_SHIFT realigns it to 10 fraction bits.
  localparam int PROD_W     = 24;
  localparam int PROD_SHIFT = 4;
  // Output-layer net value width (Q6.10).
  localparam int Z_W        = 16;

  // Largest supported number of hidden inputs and the index width it needs.
  localparam int MAX_HIDDEN = 16;
  localparam int IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/z3_sat.sv
// z3_sat: resolves the wide accumulator sum to the 16-bit Q6.10 output.
//   Purely combinational.
//   Macro Z3_SAT_EN: defined -> clamp to [0x8000, 0x7FFF];
//                    undefined -> keep the low 16 bits (wraps).
// Ports:
//   sum   in  ACC_W  signed Q14.10 sum (accumulator plus bias)
//   z3_o  out 16     resolved Q6.10 value
module z3_sat
  import nn_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [Z_W-1:0]   z3_o
);

`ifdef Z3_SAT_EN
  localparam logic signed [ACC_W-1:0] Z_MAX = ACC_W'(32'sh0000_7FFF);
  localparam logic signed [ACC_W-1:0] Z_MIN = ACC_W'(-32'sd32768);

  always_comb begin
    if (sum > Z_MAX) begin
      z3_o = 16'h7FFF;
    end else if (sum < Z_MIN) begin
      z3_o = 16'h8000;
    end else begin
      z3_o = sum[Z_W-1:0];
    end
  end
`else
  // Wrapping build: the upper bits are intentionally dropped.
  logic sum_unused;
  assign sum_unused = ^sum[ACC_W-1:Z_W];
  assign z3_o       = sum[Z_W-1:0];
`endif

endmodule

// File: rtl/z3_mac.sv
// z3_mac: output-layer neuron. Accepts N_HIDDEN (z2_in, w3_in) beats on a
//   valid/ready stream, accumulates z2*w3 at full precision, adds b3 and
//   returns the Q6.10 net value z3 on a valid/ready stream.
//   Optional macro Z3_SAT_EN (see z3_sat) selects clamping instead of wrap.
// Handshake: a beat transfers on a rising edge where s_valid && s_ready; the
//   result transfers on a rising edge where m_valid && m_ready. s_ready and
//   m_valid depend only on the registered state, and m_valid/z3 stay stable
//   until the transfer.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   s_valid    in   beat present          s_ready  out  beat accepted
//   z2_in      in   Q4.4 hidden output    w3_in    in   Q6.10 weight
//   idx        out  index of next beat (weight-memory address)
//   b3         in   Q6.10 bias, sampled in FIN
//   m_valid    out  z3 valid              m_ready  in   consumer accepts z3
//   z3         out  Q6.10 net value
//   dbg_state  out  current FSM state
module z3_mac
  import nn_pkg::*;
#(
  parameter int N_HIDDEN = 3,   // 1..MAX_HIDDEN
  parameter int ACC_W    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [HID_W-1:0] z2_in,
  input  logic [W_W-1:0]   w3_in,
  output logic [IDX_W-1:0] idx,
  input  logic [W_W-1:0]   b3,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [Z_W-1:0]   z3,
  output state_t           dbg_state
);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [IDX_W-1:0]  idx_q, idx_d;
  logic        [Z_W-1:0]    z3_q, z3_d;

  logic                     accept;
  logic                     last_beat;
  logic signed [PROD_W-1:0] z2_ext, w3_ext, prod, prod_shr;
  logic signed [ACC_W-1:0]  term, b3_ext, sum;
  logic        [Z_W-1:0]    z3_res;

  assign accept    = s_valid && s_ready;
  // Also true in IDLE when N_HIDDEN=1, so the first beat can go straight to FIN.
  assign last_beat = (idx_q == IDX_W'(N_HIDDEN - 1));

  // Operands are sign-extended to the product width so the low PROD_W bits of
  // the multiply are the exact signed product.
  assign z2_ext   = PROD_W'($signed(z2_in));
  assign w3_ext   = PROD_W'($signed(w3_in));
  assign prod     = z2_ext * w3_ext;
  assign prod_shr = prod >>> PROD_SHIFT;   // floor division, Q10.10
  assign term     = ACC_W'(prod_shr);
  assign b3_ext   = ACC_W'($signed(b3));
  assign sum      = acc_q + b3_ext;

  z3_sat #(.ACC_W(ACC_W)) u_sat (
    .sum  (sum),
    .z3_o (z3_res)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = last_beat ? FIN : ACC;
      ACC:     if (accept && last_beat) state_d = FIN;
      FIN:     state_d = OUT;
      OUT:     if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    case (state_q)
      IDLE:    s_ready = 1'b1;
      ACC:     s_ready = 1'b1;
      OUT:     m_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values.
  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    z3_d  = z3_q;
    if (accept) begin
      // IDLE always starts a fresh sum.
      acc_d = ((state_q == IDLE) ? '0 : acc_q) + term;
      idx_d = ((state_q == IDLE) ? '0 : idx_q) + IDX_W'(1);
    end
    if (state_q == FIN) begin
      z3_d = z3_res;
    end
    if ((state_q == OUT) && m_ready) begin
      acc_d = '0;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      idx_q <= '0;
      z3_q  <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      z3_q  <= z3_d;
    end
  end

  assign idx       = idx_q;
  assign z3        = z3_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_z3_mac.sv
// tb_z3_mac: directed bench for z3_mac (N_HIDDEN=3, ACC_W=24).
//   Expected z3 values are hand-computed in Q6.10 and queued per inference.
module tb_z3_mac;
  import nn_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  z2_in;
  logic [15:0] w3_in;
  logic [3:0]  idx;
  logic [15:0] b3;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] z3;
  state_t      dbg_state;

  z3_mac #(.N_HIDDEN(3), .ACC_W(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .z2_in     (z2_in),
    .w3_in     (w3_in),
    .idx       (idx),
    .b3        (b3),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .z3        (z3),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // ---------------- driver tasks ----------------
  // Beat i uses z2s[8*i +: 8] and w3s[16*i +: 16]. Called and returns at a
  // negedge; on return the last beat has just been accepted.
  task automatic feed(input logic [23:0] z2s, input logic [47:0] w3s,
                      input int max_gap, input int n_beats);
    for (int i = 0; i < n_beats; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
      for (int g = 0; g < gap; g++) begin
        s_valid = 1'b0;
        check("idx_hold_gap", 32'(idx), 32'(i));
        @(negedge clk);
      end
      s_valid = 1'b1;
      z2_in   = z2s[8*i +: 8];
      w3_in   = w3s[16*i +: 16];
      check("s_ready_beat", 32'(s_ready), 32'd1);
      check("idx_beat", 32'(idx), 32'(i));
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  // Starts at the negedge after the final beat edge E.
  task automatic collect(input int hold);
    logic [15:0] want;
    check("fin_state", 32'(dbg_state), 32'(FIN));
    check("fin_s_ready", 32'(s_ready), 32'd0);
    check("fin_m_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    want = exp_q.pop_front();
    check("out_m_valid", 32'(m_valid), 32'd1);
    check("z3", 32'(z3), 32'(want));
    for (int h = 0; h < hold; h++) begin
      m_ready = 1'b0;
      @(negedge clk);
      check("bp_m_valid", 32'(m_valid), 32'd1);
      check("bp_z3_stable", 32'(z3), 32'(want));
      check("bp_s_ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("exit_state", 32'(dbg_state), 32'(IDLE));
    check("exit_s_ready", 32'(s_ready), 32'd1);
    check("exit_m_valid", 32'(m_valid), 32'd0);
    check("exit_idx", 32'(idx), 32'd0);
    check("exit_z3_held", 32'(z3), 32'(want));
  endtask

  task automatic run(input logic [23:0] z2s, input logic [47:0] w3s, input logic [15:0] b3v,
                     input logic [15:0] want, input int max_gap, input int hold);
    b3 = b3v;
    exp_q.push_back(want);
    feed(z2s, w3s, max_gap, 3);
    collect(hold);
  endtask

  // Beat 0 sits in the least significant slot.
  localparam logic [23:0] BASIC_Z2 = {8'hF0, 8'h20, 8'h10};        // -1, 2, 1
  localparam logic [47:0] BASIC_W3 = {16'h0400, 16'h0400, 16'h0400};

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    z2_in   = '0;
    w3_in   = '0;
    b3      = '0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_z3", 32'(z3), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;
    @(negedge clk);

    // Basic sum: 1 + 2 - 1 + 0.5 = 2.5
    run(BASIC_Z2, BASIC_W3, 16'h0200, 16'h0A00, 0, 0);

    // Positive overflow: 3 * floor(127*32767/16) = 780264
`ifdef Z3_SAT_EN
    run({3{8'h7F}}, {3{16'h7FFF}}, 16'h0000, 16'h7FFF, 0, 0);
    run({3{8'h80}}, {3{16'h7FFF}}, 16'h0000, 16'h8000, 0, 0);
`else
    run({3{8'h7F}}, {3{16'h7FFF}}, 16'h0000, 16'hE7E8, 0, 0);
    // Negative overflow: -786408 wraps to 0x0018
    run({3{8'h80}}, {3{16'h7FFF}}, 16'h0000, 16'h0018, 0, 0);
`endif

    // Shift rounds toward -inf: each (1/16)*(-1/1024) term contributes -1 LSB.
    run({3{8'h01}}, {3{16'hFFFF}}, 16'h0000, 16'hFFFD, 0, 0);

    // Gapped input.
    run(BASIC_Z2, BASIC_W3, 16'h0200, 16'h0A00, 4, 0);

    // Backpressure, mixed signs: 0.5*2 + (-4)*0.5 + 3*(-1) + 0.25 = -3.75
    run({8'h30, 8'hC0, 8'h08}, {16'hFC00, 16'h0200, 16'h0800}, 16'h0100, 16'hF100, 0, 5);

    // Reset mid-inference after two accepted beats.
    b3 = 16'h0200;
    feed(BASIC_Z2, BASIC_W3, 0, 2);
    check("mid_idx", 32'(idx), 32'd2);
    check("mid_state", 32'(dbg_state), 32'(ACC));
    reset = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_z3", 32'(z3), 32'd0);
    check("mid_rst_idx", 32'(idx), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(BASIC_Z2, BASIC_W3, 16'h0200, 16'h0A00, 0, 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/z3_mac.md
# z3_mac

Output-layer neuron for the backpropagation network; it sits directly downstream of the hidden-layer neurons. It accepts the N_HIDDEN saturated 8-bit hidden outputs as a serial valid/ready stream, with one weight per beat. Each beat is multiplied by its weight and accumulated at full precision. After the final beat the block adds the output bias and returns a 16-bit Q6.10 result through a valid/ready handshake.

## Interface
- N_HIDDEN, 3, number of hidden-layer inputs per inference (1..16)
- ACC_W, 24, accumulator width in bits (Q14.10)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  hidden value and weight present
- s_ready  out  1  block accepts a beat
- z2_in  in  8  signed Q4.4 hidden-layer output
- w3_in  in  16  signed Q6.10 weight paired with z2_in
- idx  out  4  index of the next beat to accept (weight-memory address)
- b3  in  16  signed Q6.10 output bias, sampled in FIN
- m_valid  out  1  z3 valid
- m_ready  in  1  consumer accepts z3
- z3  out  16  signed Q6.10 output-layer net value

## Operation
- States:
  - IDLE: s_ready=1; acc and idx cleared.
  - ACC: s_ready=1.
  - FIN: s_ready=0.
  - OUT: s_ready=0; m_valid=1.
- A beat is accepted on a rising edge where s_valid && s_ready.
- On each accepted beat:
  - prod = z2_in * w3_in, a 24-bit signed Q10.14 value.
  - term = prod >>> 4, arithmetic shift, rounding toward -inf; result is Q10.10, sign-extended to ACC_W.
  - acc += term; idx += 1.
- State transitions:
  - IDLE to ACC on the first accepted beat.
  - ACC, or IDLE when N_HIDDEN=1, to FIN on acceptance of beat N_HIDDEN-1.
  - FIN: acc + sign-extended b3 is resolved to 16 bits (see Configuration) and registered into z3; then OUT.
  - OUT to IDLE on the edge where m_ready=1. acc and idx clear on that edge.
- With s_valid low, state, acc and idx hold. Gaps between beats do not change the result.
- z3 holds its value from the FIN edge until the next FIN edge.
- Reset values: state=IDLE, acc=0, idx=0, z3=0, m_valid=0. s_ready=1 after reset because the block is in IDLE.
- Reset mid-inference discards all partial sums. No beat is accepted while reset is low.

## Timing
- s_ready and m_valid are decoded from registered state only, with no input-to-output combinational path.
- Let E be the edge accepting the final beat. The block is in FIN during the cycle after E. m_valid and z3 are valid after edge E+1.
- Minimum period per inference is N_HIDDEN+2 cycles: N beats, FIN, and one OUT cycle with m_ready high.
- The first beat of the next inference is accepted no earlier than the cycle after OUT exits.
- m_valid never drops without an m_ready handshake. z3 is stable while m_valid=1.

## Configuration
- Macro Z3_SAT_EN.
- Defined: in FIN, a sum above 32767 gives z3=0x7FFF, and a sum below -32768 gives z3=0x8000.
- Undefined: z3 = sum[15:0], which wraps. No comparison logic is built.

## Structure
- Shared package nn_pkg holds:
  - Q-format widths: HID_W=8, W_W=16, PROD_W=24, PROD_SHIFT=4.
  - The state enum {IDLE, ACC, FIN, OUT}.
  - The maximum N_HIDDEN.
- One natural sub-module, z3_sat. It takes an ACC_W-bit sum and returns the 16-bit clamped or wrapped value under Z3_SAT_EN, and is purely combinational.

## Test plan
- Basic sum:
  - Stimulus: N=3, z2_in=0x10,0x20,0xF0 (1, 2, -1), w3_in=0x0400 for each beat, b3=0x0200.
  - Response: z3=0x0A00 (2.5). m_valid rises after edge E+1.
- Positive overflow:
  - Stimulus: z2_in=0x7F, w3_in=0x7FFF for all 3 beats, b3=0.
  - Response: z3=0x7FFF with Z3_SAT_EN; z3=0xE7E8 without.
- Negative overflow:
  - Stimulus: z2_in=0x80, w3_in=0x7FFF for all 3 beats, b3=0.
  - Response: z3=0x8000 with Z3_SAT_EN.
- Gapped input:
  - Stimulus: the basic-sum inputs with s_valid low for 1–4 random cycles between beats.
  - Response: z3=0x0A00. idx steps 0, 1, 2 only on accepted beats.
- Backpressure:
  - Stimulus: m_ready low for 5 cycles in OUT.
  - Response: m_valid=1, z3 stable and s_ready=0 throughout. After the m_ready=1 edge, the block is in IDLE with s_ready=1.
- Reset mid-inference:
  - Stimulus: reset low after 2 accepted beats, then released, then a fresh basic-sum inference.
  - Response: immediately on reset, m_valid=0, z3=0, idx=0. The fresh inference gives z3=0x0A00.
